// File: rtl/clock_set_ctrl.sv
// Time-set controller for the BCD clock: run enable, hour/minute set sequence, shadow display, commit load.
// Optional auto-repeat on a held increment button is enabled with CLOCK_SET_REPEAT_EN.
module clock_set_ctrl #(
  parameter int unsigned TIMEOUT_S  = 30
`ifdef CLOCK_SET_REPEAT_EN
  , parameter int unsigned REPEAT_DLY = 25000000,
  parameter int unsigned REPEAT_PER = 5000000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
`ifdef CLOCK_SET_REPEAT_EN
  input  logic       btn_inc_hold,
`endif
  input  logic [7:0] cur_h,
  input  logic [7:0] cur_m,
  output logic       run_en,
  output logic       load,
  output logic [7:0] load_h,
  output logic [7:0] load_m,
  output logic       clear_s,
  output logic [1:0] set_mode,
  output logic [7:0] disp_h,
  output logic [7:0] disp_m,
  output logic [5:0] blink_mask
);

  typedef enum logic [1:0] {RUN = 2'd0, SET_H = 2'd1, SET_M = 2'd2, COMMIT = 2'd3} state_t;

  state_t     state, state_n;
  logic [7:0] sh_h, sh_h_n, sh_m, sh_m_n;
  logic [7:0] tmo, tmo_n;
  logic       phase, phase_n;
  logic       inc_ev;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max)          return 8'h00;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                   return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Corrupt counter values must not leak into the set sequence.
  function automatic logic [7:0] bcd_norm(input logic [7:0] v, input logic [7:0] max);
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v > max) return 8'h00;
    else                                           return v;
  endfunction

`ifdef CLOCK_SET_REPEAT_EN
  logic [31:0] rep_cnt;
  logic        rep_on, rep_pulse, in_set;

  assign in_set    = (state == SET_H) || (state == SET_M);
  assign rep_pulse = in_set && btn_inc_hold &&
                     (rep_on ? (rep_cnt == 32'(REPEAT_PER - 1)) : (rep_cnt == 32'(REPEAT_DLY - 1)));
  assign inc_ev    = btn_inc | rep_pulse;

  always_ff @(posedge clk) begin
    if (reset || !btn_inc_hold || !in_set) begin
      rep_cnt <= '0;
      rep_on  <= 1'b0;
    end else if (rep_pulse) begin
      rep_cnt <= '0;
      rep_on  <= 1'b1;
    end else begin
      rep_cnt <= rep_cnt + 32'd1;
    end
  end
`else
  assign inc_ev = btn_inc;
`endif

  always_comb begin
    state_n = state;
    sh_h_n  = sh_h;
    sh_m_n  = sh_m;
    phase_n = phase;
    tmo_n   = tmo;
    case (state)
      RUN: begin
        phase_n = 1'b0;
        tmo_n   = 8'd0;
        if (btn_mode) begin
          state_n = SET_H;
          sh_h_n  = bcd_norm(cur_h, 8'h23);
          sh_m_n  = bcd_norm(cur_m, 8'h59);
          phase_n = 1'b1;
        end
      end
      SET_H, SET_M: begin
        if (tick_1hz) begin
          phase_n = ~phase;
          tmo_n   = tmo + 8'd1;
        end
        if (btn_mode || inc_ev) tmo_n = 8'd0;
        // Mode wins over a coincident increment; any button cancels an expiring abort.
        if (btn_mode) begin
          state_n = (state == SET_H) ? SET_M : COMMIT;
        end else if (inc_ev) begin
          if (state == SET_H) sh_h_n = bcd_inc(sh_h, 8'h23);
          else                sh_m_n = bcd_inc(sh_m, 8'h59);
        end else if (tick_1hz && (tmo + 8'd1) == TIMEOUT_S[7:0]) begin
          state_n = RUN;
        end
      end
      COMMIT: begin
        state_n = RUN;
        phase_n = 1'b0;
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      sh_h  <= 8'h00;
      sh_m  <= 8'h00;
      phase <= 1'b0;
      tmo   <= 8'd0;
    end else begin
      state <= state_n;
      sh_h  <= sh_h_n;
      sh_m  <= sh_m_n;
      phase <= phase_n;
      tmo   <= tmo_n;
    end
  end

  // Outputs are decoded from next-state values so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_en     <= 1'b1;
      load       <= 1'b0;
      clear_s    <= 1'b0;
      load_h     <= 8'h00;
      load_m     <= 8'h00;
      blink_mask <= 6'b0;
    end else begin
      run_en  <= (state_n == RUN);
      load    <= (state_n == COMMIT);
      clear_s <= (state_n == COMMIT);
      if (state_n == COMMIT) begin
        load_h <= sh_h_n;
        load_m <= sh_m_n;
      end
      if      (state_n == SET_H && phase_n) blink_mask <= 6'b110000;
      else if (state_n == SET_M && phase_n) blink_mask <= 6'b001100;
      else                                  blink_mask <= 6'b000000;
    end
  end

  assign set_mode = state;
  assign disp_h   = (state == RUN) ? cur_h : sh_h;
  assign disp_m   = (state == RUN) ? cur_m : sh_m;

endmodule
